// File: rtl/cpf3_io_pkg.sv
// ----------------------------------------------------------------------------
// cpf3_io_pkg
// Shared constants for the CPF3 input-port front end: default channel width,
// channel index map, default synchroniser/debounce depths, and a width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package cpf3_io_pkg;

    localparam int CPF3_DATA_W          = 16;
    localparam int CPF3_N_CH            = 4;
    localparam int CPF3_SYNC_STAGES     = 2;
    localparam int CPF3_DEBOUNCE_CYCLES = 4;

    // Default channel map
    localparam int CH_KEYPAD = 0;
    localparam int CH_ADC0   = 1;
    localparam int CH_PORTD  = 2;
    localparam int CH_SP1    = 3;

    // clog2 that never returns less than 1, so counters/selects keep a real bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_debounce_chan.sv
// ----------------------------------------------------------------------------
// io_debounce_chan
// One input channel: multi-flop synchroniser followed by a whole-word
// debouncer. The debounced value commits only after the synchronised word has
// matched the candidate for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   i_async   in   raw asynchronous input word
//   o_stable  out  debounced (committed) word
//   o_commit  out  combinational 1-cycle pulse, high in the cycle whose
//                  rising edge loads a new value into o_stable
// ----------------------------------------------------------------------------
module io_debounce_chan
    import cpf3_io_pkg::*;
#(
    parameter int DATA_W          = CPF3_DATA_W,
    parameter int SYNC_STAGES     = CPF3_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = CPF3_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_async,
    output logic [DATA_W-1:0] o_stable,
    output logic              o_commit
);

    localparam int                CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] r_sync [SYNC_STAGES];
    logic [DATA_W-1:0] r_cand;
    logic [DATA_W-1:0] r_stable;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] w_sync_q;
    logic              w_commit;

    // Synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= i_async;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // Commit fires on the last counted cycle of a steady, differing candidate.
    // The counter is cleared on commit, so it never reaches DEBOUNCE_CYCLES.
    assign w_commit = (w_sync_q == r_cand) && (r_cand != r_stable) && (r_cnt == CNT_LAST);

    // Debounce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else if (w_sync_q != r_cand) begin
            r_cand <= w_sync_q;
            r_cnt  <= '0;
        end else if (r_cand != r_stable) begin
            if (r_cnt == CNT_LAST) begin
                r_stable <= r_cand;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_stable = r_stable;
    assign o_commit = w_commit;

endmodule

// File: rtl/io_input_latch_bank.sv
// ----------------------------------------------------------------------------
// io_input_latch_bank
// Input-port front end for the CPF3 softcore. Each channel is synchronised and
// debounced; a latch strobe snapshots every debounced word into the
// processor-visible latched registers. Each committed change sets a sticky
// per-channel flag that can raise a maskable interrupt.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   port_in       in   raw async inputs, channel i at [i*DATA_W +: DATA_W]
//   latch_en      in   snapshot strobe, all channels
//   latch_done    out  registered pulse, the edge after latch_en is sampled
//   rd_sel        in   channel select for rd_data
//   rd_data       out  latched[rd_sel] (combinational), 0 if out of range
//   latched_flat  out  all latched registers, same packing as port_in
//   chg_pending   out  per-channel committed-change flag
//   chg_clr       in   per-channel flag clear
//   irq_mask      in   1 = channel may raise irq
//   irq           out  registered |(chg_pending & irq_mask)
// ----------------------------------------------------------------------------
module io_input_latch_bank
    import cpf3_io_pkg::*;
#(
    parameter int DATA_W          = CPF3_DATA_W,
    parameter int N_CH            = CPF3_N_CH,
    parameter int SYNC_STAGES     = CPF3_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = CPF3_DEBOUNCE_CYCLES,
    parameter int SEL_W           = clog2_min1(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] port_in,
    input  logic                   latch_en,
    output logic                   latch_done,
    input  logic [SEL_W-1:0]       rd_sel,
    output logic [DATA_W-1:0]      rd_data,
    output logic [N_CH*DATA_W-1:0] latched_flat,
    output logic [N_CH-1:0]        chg_pending,
    input  logic [N_CH-1:0]        chg_clr,
    input  logic [N_CH-1:0]        irq_mask,
    output logic                   irq
);

    logic [N_CH-1:0][DATA_W-1:0] w_stable;
    logic [N_CH-1:0]             w_commit;
    logic [N_CH-1:0][DATA_W-1:0] r_latched;
    logic [N_CH-1:0]             r_chg;
    logic                        r_irq;
    logic                        r_latch_done;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        io_debounce_chan #(
            .DATA_W          (DATA_W),
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .i_async  (port_in[g*DATA_W +: DATA_W]),
            .o_stable (w_stable[g]),
            .o_commit (w_commit[g])
        );
    end

    // Snapshot takes the registered stable value, so a commit landing on the
    // same edge is not captured until the next strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_latched    <= '0;
            r_latch_done <= 1'b0;
        end else begin
            if (latch_en) begin
                r_latched <= w_stable;
            end
            r_latch_done <= latch_en;
        end
    end

    // Set has priority over clear so a commit is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chg <= '0;
            r_irq <= 1'b0;
        end else begin
            r_chg <= (r_chg & ~chg_clr) | w_commit;
            r_irq <= |(r_chg & irq_mask);
        end
    end

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data = r_latched[i];
            end
        end
    end

    assign latched_flat = r_latched;
    assign chg_pending  = r_chg;
    assign irq          = r_irq;
    assign latch_done   = r_latch_done;

endmodule

// File: tb/tb_io_input_latch_bank.sv
module tb_io_input_latch_bank;

    localparam int DW = 16;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC*DW-1:0] port_in;
    logic            latch_en;
    logic            latch_done;
    logic [1:0]      rd_sel;
    logic [DW-1:0]   rd_data;
    logic [NC*DW-1:0] latched_flat;
    logic [NC-1:0]   chg_pending;
    logic [NC-1:0]   chg_clr;
    logic [NC-1:0]   irq_mask;
    logic            irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_input_latch_bank #(
        .DATA_W          (DW),
        .N_CH            (NC),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_in      (port_in),
        .latch_en     (latch_en),
        .latch_done   (latch_done),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .latched_flat (latched_flat),
        .chg_pending  (chg_pending),
        .chg_clr      (chg_clr),
        .irq_mask     (irq_mask),
        .irq          (irq)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] v);
        port_in[ch*DW +: DW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; port_in = '0; latch_en = 1'b0; rd_sel = '0;
        chg_clr = '0; irq_mask = '0;
        tick(2);
        n_cmp++;
        if (latched_flat !== '0 || chg_pending !== '0 || irq !== 1'b0 || latch_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: latched=%h chg=%b irq=%b done=%b want all 0",
                     latched_flat, chg_pending, irq, latch_done);
        end
        rst = 1'b0;
        tick(10);
        n_cmp++;
        if (latched_flat !== '0 || chg_pending !== '0 || irq !== 1'b0 || latch_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: latched=%h chg=%b irq=%b done=%b want all 0",
                     latched_flat, chg_pending, irq, latch_done);
        end
        for (int s = 0; s < NC; s++) begin
            rd_sel = 2'(s);
            #1;
            n_cmp++;
            if (rd_data !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_rd_sel%0d: got %h want 0000", s, rd_data);
            end
        end
    endtask

    task automatic test_commit_ch0();
        irq_mask = 4'b1111;
        set_ch(0, 16'h0088);
        tick(6);
        n_cmp++;
        if (chg_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL ch0_early: chg=%b want 0000 after 6 edges", chg_pending);
        end
        tick(1);
        n_cmp++;
        if (chg_pending !== 4'b0001 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL ch0_commit: chg=%b irq=%b want 0001 irq 0", chg_pending, irq);
        end
        tick(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL ch0_irq: got %b want 1", irq);
        end
        latch_en = 1'b1;
        tick(1);
        latch_en = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_cmp++;
        if (rd_data !== 16'h0088 || latch_done !== 1'b1) begin
            n_err++;
            $display("FAIL ch0_latch: rd=%h done=%b want 0088 done 1", rd_data, latch_done);
        end
        tick(1);
        n_cmp++;
        if (latch_done !== 1'b0) begin
            n_err++;
            $display("FAIL ch0_done_pulse: got %b want 0", latch_done);
        end
        chg_clr = 4'b0001;
        tick(1);
        chg_clr = '0;
        n_cmp++;
        if (chg_pending !== 4'b0000 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL ch0_clr: chg=%b irq=%b want 0000 irq 1", chg_pending, irq);
        end
        tick(1);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL ch0_irq_drop: got %b want 0", irq);
        end
    endtask

    task automatic test_glitch_ch1();
        set_ch(1, 16'h0011);
        tick(3);
        set_ch(1, 16'h0000);
        tick(12);
        n_cmp++;
        if (chg_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL ch1_glitch_flag: chg=%b want 0000", chg_pending);
        end
        latch_en = 1'b1;
        tick(1);
        latch_en = 1'b0;
        n_cmp++;
        if (latched_flat[31:16] !== 16'h0000 || latched_flat[15:0] !== 16'h0088) begin
            n_err++;
            $display("FAIL ch1_glitch_latch: ch1=%h ch0=%h want 0000 0088",
                     latched_flat[31:16], latched_flat[15:0]);
        end
    endtask

    task automatic test_same_cycle_ch2();
        set_ch(2, 16'h0002);
        tick(6);
        chg_clr  = 4'b0100;
        latch_en = 1'b1;
        tick(1);
        chg_clr  = '0;
        latch_en = 1'b0;
        n_cmp++;
        if (chg_pending !== 4'b0100) begin
            n_err++;
            $display("FAIL ch2_set_wins: chg=%b want 0100", chg_pending);
        end
        n_cmp++;
        if (latched_flat[47:32] !== 16'h0000) begin
            n_err++;
            $display("FAIL ch2_precommit_latch: got %h want 0000", latched_flat[47:32]);
        end
        latch_en = 1'b1;
        tick(1);
        latch_en = 1'b0;
        rd_sel = 2'd2;
        #1;
        n_cmp++;
        if (rd_data !== 16'h0002 || chg_pending !== 4'b0100) begin
            n_err++;
            $display("FAIL ch2_relatch: rd=%h chg=%b want 0002 0100", rd_data, chg_pending);
        end
        chg_clr = 4'b0100;
        tick(2);
        chg_clr = '0;
    endtask

    task automatic test_back_to_back();
        latch_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            n_cmp++;
            if (latch_done !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_done%0d: got %b want 1", k, latch_done);
            end
        end
        latch_en = 1'b0;
        tick(1);
        n_cmp++;
        if (latch_done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_end: got %b want 0", latch_done);
        end
    endtask

    task automatic test_mask_ch3();
        irq_mask = 4'b0111;
        set_ch(3, 16'h0003);
        tick(7);
        n_cmp++;
        if (chg_pending !== 4'b1000) begin
            n_err++;
            $display("FAIL ch3_commit: chg=%b want 1000", chg_pending);
        end
        tick(1);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL ch3_masked_irq: got %b want 0", irq);
        end
        irq_mask = 4'b1111;
        tick(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL ch3_unmask_irq: got %b want 1", irq);
        end
        chg_clr = 4'b1000;
        tick(1);
        chg_clr = '0;
        tick(1);
        n_cmp++;
        if (irq !== 1'b0 || chg_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL ch3_clr_irq: irq=%b chg=%b want 0 0000", irq, chg_pending);
        end
    endtask

    task automatic test_reset_mid_debounce();
        set_ch(0, 16'h0055);
        tick(5);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (latched_flat !== '0 || chg_pending !== '0 || irq !== 1'b0 || latch_done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_clear: latched=%h chg=%b irq=%b done=%b want all 0",
                     latched_flat, chg_pending, irq, latch_done);
        end
        tick(2);
        rst = 1'b0;
        tick(6);
        n_cmp++;
        if (chg_pending !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_early: chg=%b want 0000 after 6 edges", chg_pending);
        end
        tick(1);
        n_cmp++;
        if (chg_pending !== 4'b1101) begin
            n_err++;
            $display("FAIL midrst_recommit: chg=%b want 1101", chg_pending);
        end
        latch_en = 1'b1;
        tick(1);
        latch_en = 1'b0;
        rd_sel = 2'd0;
        #1;
        n_cmp++;
        if (rd_data !== 16'h0055 || latched_flat !== 64'h0003_0002_0000_0055) begin
            n_err++;
            $display("FAIL midrst_latch: rd=%h flat=%h want 0055 0003000200000055",
                     rd_data, latched_flat);
        end
    endtask

    initial begin
        test_reset();
        test_commit_ch0();
        test_glitch_ch1();
        test_same_cycle_ch2();
        test_back_to_back();
        test_mask_ch3();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
